dm_ext: RTL and testbench

Parametrised data memory for the MIPS pipeline MEM stage. Generalises the word-only DM with:
- configurable depth, base address and read latency
- sb/sh/sw stores with byte-lane merging
- lb/lbu/lh/lhu/lw loads with sign or zero extension
- alignment and range checking
- a sequential clear engine that zeroes the array after reset, one word per cycle.

---
 rtl/dm_ext_if.sv | 39 +++
 rtl/dm_ext.sv | 154 +++++++++++++++
 tb/tb_dm_ext.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/dm_ext_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dm_ext_if
// Purpose  : Bus bundle between the MEM stage (master) and the data memory
//            dm_ext (slave).
// Signals  : mem_write  store request this cycle
//            mem_read   load request this cycle
//            mem_op     access size / extension select
//            mem_addr   byte address
//            wd         store data (low-order bits used for half/byte)
//            pc         PC of the instruction, trace only
//            rd         load data, extended per mem_op
//            busy       clear engine running, accesses ignored
//            addr_exc   misaligned or out-of-range access
// Revision : 1.0 - initial release
// ============================================================================
interface dm_ext_if;
  logic        mem_write;
  logic        mem_read;
  logic [2:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] wd;
  logic [31:0] pc;
  logic [31:0] rd;
  logic        busy;
  logic        addr_exc;

  modport master (
    output mem_write, mem_read, mem_op, mem_addr, wd, pc,
    input  rd, busy, addr_exc
  );

  modport slave (
    input  mem_write, mem_read, mem_op, mem_addr, wd, pc,
    output rd, busy, addr_exc
  );
endinterface
`default_nettype wire

// File: rtl/dm_ext.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dm_ext
// Purpose  : Parametrised MIPS data memory. Byte/half/word stores with lane
//            merging, signed/unsigned loads, alignment and range checking,
//            and a clear engine that zeroes one word per cycle after reset.
// Ports    : clk    clock, all state changes on posedge
//            reset  asynchronous active-low reset (0 = in reset)
//            bus    dm_ext_if.slave (mem_write, mem_read, mem_op, mem_addr,
//                   wd, pc in; rd, busy, addr_exc out)
// Params   : DEPTH (words, power of two >= 4), BASE (byte address of word 0),
//            READ_LAT (0 = combinational rd, 1 = registered rd)
// Options  : define DM_TRACE_EN to print accepted stores and exceptions
// Revision : 1.0 - initial release
// ============================================================================
module dm_ext #(
  parameter int          DEPTH    = 1024,
  parameter logic [31:0] BASE     = 32'h0000_0000,
  parameter int          READ_LAT = 0
) (
  input  wire logic clk,
  input  wire logic reset,
  dm_ext_if.slave   bus
);

  localparam int             AW     = $clog2(DEPTH);
  localparam logic [32:0]    SPAN   = 33'(DEPTH) * 33'd4;
  localparam logic [AW-1:0]  LAST   = AW'(DEPTH - 1);
  localparam logic [2:0]     OP_HU  = 3'b001;
  localparam logic [2:0]     OP_HS  = 3'b010;
  localparam logic [2:0]     OP_BU  = 3'b011;
  localparam logic [2:0]     OP_BS  = 3'b100;

  typedef enum logic [0:0] {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t         state_q;
  logic [AW-1:0]  ptr_q;
  logic [31:0]    mem_q [DEPTH];

  logic           w_busy, w_in_range, w_misalign, w_exc;
  logic           w_is_half, w_is_byte, w_is_word;
  logic [1:0]     w_lane;
  logic [31:0]    w_off, w_old, w_new, w_merged, w_ext, w_rd_data, w_wdata;
  logic [15:0]    w_half;
  logic [7:0]     w_byte;
  logic [3:0]     w_be;
  logic [AW-1:0]  w_idx, w_widx;
  logic           w_we;

  // Clear engine: sweeps every word once, then stays in RUN until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else if (state_q == CLEAR) begin
      ptr_q <= ptr_q + AW'(1);
      if (ptr_q == LAST) state_q <= RUN;
    end
  end

  assign w_busy = (state_q == CLEAR);

  // The subtraction never wraps into range because mem_addr >= BASE is
  // required as well, so addresses below BASE cannot alias into the array.
  assign w_off      = bus.mem_addr - BASE;
  assign w_in_range = (bus.mem_addr >= BASE) && ({1'b0, w_off} < SPAN);
  assign w_idx      = w_off[AW+1:2];
  assign w_lane     = bus.mem_addr[1:0];

  assign w_is_half  = (bus.mem_op == OP_HU) || (bus.mem_op == OP_HS);
  assign w_is_byte  = (bus.mem_op == OP_BU) || (bus.mem_op == OP_BS);
  assign w_is_word  = !(w_is_half || w_is_byte);
  assign w_misalign = (w_is_word && (w_lane != 2'b00)) || (w_is_half && w_lane[0]);
  assign w_exc      = (bus.mem_read | bus.mem_write) & ~w_busy & (w_misalign | ~w_in_range);

  assign w_old  = mem_q[w_idx];
  assign w_half = w_lane[1] ? w_old[31:16] : w_old[15:0];
  assign w_byte = w_old[{w_lane, 3'b000} +: 8];

  // Store data is replicated into every lane; the byte enables pick the lanes.
  always_comb begin
    w_be  = 4'b1111;
    w_new = bus.wd;
    if (w_is_half) begin
      w_be  = w_lane[1] ? 4'b1100 : 4'b0011;
      w_new = {2{bus.wd[15:0]}};
    end else if (w_is_byte) begin
      w_be  = 4'b0001 << w_lane;
      w_new = {4{bus.wd[7:0]}};
    end
    w_merged = w_old;
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) w_merged[8*b +: 8] = w_new[8*b +: 8];
    end
  end

  always_comb begin
    w_ext = w_old;
    case (bus.mem_op)
      OP_HU:   w_ext = {16'h0000, w_half};
      OP_HS:   w_ext = {{16{w_half[15]}}, w_half};
      OP_BU:   w_ext = {24'h000000, w_byte};
      OP_BS:   w_ext = {{24{w_byte[7]}}, w_byte};
      default: w_ext = w_old;
    endcase
  end

  assign w_rd_data = (bus.mem_read & ~w_busy & ~w_exc) ? w_ext : 32'h0;

  // Single write port shared by the clear engine and stores. Gating with
  // reset keeps the array untouched while reset is held.
  assign w_we    = reset & (w_busy | (bus.mem_write & ~w_exc));
  assign w_widx  = w_busy ? ptr_q : w_idx;
  assign w_wdata = w_busy ? 32'h0 : w_merged;

  always_ff @(posedge clk) begin
    if (w_we) mem_q[w_widx] <= w_wdata;
  end

  generate
    if (READ_LAT == 0) begin : g_rd_comb
      assign bus.rd = w_rd_data;
    end else begin : g_rd_reg
      logic [31:0] rd_q;
      // Captures pre-edge array contents, giving read-before-write ordering.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_q <= '0;
        else        rd_q <= w_rd_data;
      end
      assign bus.rd = rd_q;
    end
  endgenerate

  assign bus.busy     = w_busy;
  assign bus.addr_exc = w_exc;

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && !w_busy) begin
      if (bus.mem_write && !w_exc)
        $display("%0t@%h: *%h <= %h", $time, bus.pc, {bus.mem_addr[31:2], 2'b00}, w_merged);
      if (w_exc)
        $display("%0t@%h: DM EXC %h", $time, bus.pc, bus.mem_addr);
    end
  end
`else
  // pc only feeds the trace; fold it away when tracing is disabled.
  logic w_unused_pc;
  assign w_unused_pc = ^bus.pc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_ext.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dm_ext
// Purpose  : Directed self-checking bench for dm_ext. dut0 is DEPTH=1024,
//            BASE=0, combinational read; dut1 is DEPTH=64, BASE=0x1000_0000,
//            registered read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_ext;
  localparam logic [2:0] W  = 3'b000;
  localparam logic [2:0] HU = 3'b001;
  localparam logic [2:0] HS = 3'b010;
  localparam logic [2:0] BU = 3'b011;
  localparam logic [2:0] BS = 3'b100;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   c0, c1;
  logic busy_ok;

  always #5 clk = ~clk;

  dm_ext_if bus0 ();
  dm_ext_if bus1 ();

  dm_ext #(.DEPTH(1024), .BASE(32'h0000_0000), .READ_LAT(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  dm_ext #(.DEPTH(64), .BASE(32'h1000_0000), .READ_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one access at the falling edge, then settle for sampling.
  task automatic d0(input logic w, input logic r, input logic [2:0] op,
                    input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus0.mem_write = w; bus0.mem_read = r; bus0.mem_op = op;
    bus0.mem_addr = a; bus0.wd = d; bus0.pc = bus0.pc + 32'd4;
    #2;
  endtask

  task automatic d1(input logic w, input logic r, input logic [2:0] op,
                    input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus1.mem_write = w; bus1.mem_read = r; bus1.mem_op = op;
    bus1.mem_addr = a; bus1.wd = d; bus1.pc = bus1.pc + 32'd4;
    #2;
  endtask

  // Releases reset and counts sampled cycles with busy high (bounded).
  task automatic release_and_count(output int n0, output int n1);
    @(negedge clk);
    reset = 1'b1;
    n0 = 0; n1 = 0;
    for (int k = 0; k < 3000; k++) begin
      #2;
      if (bus0.busy) n0++;
      if (bus1.busy) n1++;
      if (!bus0.busy && !bus1.busy) break;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bus0.mem_write = 0; bus0.mem_read = 0; bus0.mem_op = W; bus0.mem_addr = 0; bus0.wd = 0; bus0.pc = 32'h0040_0000;
    bus1.mem_write = 0; bus1.mem_read = 0; bus1.mem_op = W; bus1.mem_addr = 0; bus1.wd = 0; bus1.pc = 32'h0080_0000;
    #1 reset = 1'b0;

    // Reset state: busy, no exception even for a misaligned access, rd zero
    d0(0, 1, W, 32'h0000_0002, 0);
    d1(0, 1, W, 32'h1000_0040, 0);
    chk("rst_busy0", {31'b0, bus0.busy}, 32'd1);
    chk("rst_exc0",  {31'b0, bus0.addr_exc}, 32'd0);
    chk("rst_rd0",   bus0.rd, 32'h0);
    chk("rst_busy1", {31'b0, bus1.busy}, 32'd1);
    chk("rst_rd1",   bus1.rd, 32'h0);
    d0(0, 0, W, 0, 0);
    d1(0, 0, W, 32'h1000_0000, 0);
    repeat (3) @(negedge clk);

    // Clear sweep length
    release_and_count(c0, c1);
    chk("busy_cnt0", c0, 32'd1024);
    chk("busy_cnt1", c1, 32'd64);

    // Cleared contents
    d0(0, 1, W, 32'h0000_0010, 0); chk("clr_10",  bus0.rd, 32'h0);
    d0(0, 1, W, 32'h0000_0020, 0); chk("clr_20",  bus0.rd, 32'h0);
    d0(0, 1, W, 32'h0000_0FFC, 0); chk("clr_ffc", bus0.rd, 32'h0);

    // sw + sb merge, signed/unsigned loads
    d0(1, 0, W,  32'h0000_0010, 32'h1122_3344);
    d0(1, 0, BU, 32'h0000_0012, 32'hFFFF_12AB);
    d0(0, 1, W,  32'h0000_0010, 0); chk("lw_10",   bus0.rd, 32'h11AB_3344);
    d0(0, 1, BS, 32'h0000_0012, 0); chk("lb_12",   bus0.rd, 32'hFFFF_FFAB);
    d0(0, 1, BU, 32'h0000_0012, 0); chk("lbu_12",  bus0.rd, 32'h0000_00AB);
    d0(0, 1, HS, 32'h0000_0012, 0); chk("lh_12",   bus0.rd, 32'h0000_11AB);
    d0(0, 1, HU, 32'h0000_0010, 0); chk("lhu_10",  bus0.rd, 32'h0000_3344);
    d0(0, 1, BS, 32'h0000_0013, 0); chk("lb_13",   bus0.rd, 32'h0000_0011);

    // sh and halfword loads
    d0(1, 0, HU, 32'h0000_0020, 32'hCAFE_8001);
    d0(0, 1, HS, 32'h0000_0020, 0); chk("lh_20",   bus0.rd, 32'hFFFF_8001);
    d0(0, 1, HU, 32'h0000_0020, 0); chk("lhu_20",  bus0.rd, 32'h0000_8001);
    d0(0, 1, W,  32'h0000_0020, 0); chk("lw_20",   bus0.rd, 32'h0000_8001);
    d0(1, 0, HS, 32'h0000_0022, 32'h1234_7FFF);
    d0(0, 1, W,  32'h0000_0020, 0); chk("lw_20b",  bus0.rd, 32'h7FFF_8001);
    d0(0, 1, 3'b111, 32'h0000_0020, 0); chk("op7_word", bus0.rd, 32'h7FFF_8001);
    d0(0, 1, BU, 32'h0000_0023, 0); chk("lbu_23",  bus0.rd, 32'h0000_007F);
    d0(1, 0, W,  32'h0000_0FFC, 32'hA5A5_A5A5);

    // Exceptions: rd forced to zero, stores dropped
    d0(0, 1, W,  32'h0000_0022, 0);
    chk("exc_lw22", {31'b0, bus0.addr_exc}, 32'd1); chk("exc_lw22_rd", bus0.rd, 32'h0);
    d0(1, 0, HU, 32'h0000_0021, 32'h0000_FFFF);
    chk("exc_sh21", {31'b0, bus0.addr_exc}, 32'd1);
    d0(1, 0, W,  32'h0000_1000, 32'hDEAD_DEAD);
    chk("exc_sw_top", {31'b0, bus0.addr_exc}, 32'd1);
    d0(1, 0, W,  32'h0000_0FFE, 32'h0000_0BAD);
    chk("exc_sw_ffe", {31'b0, bus0.addr_exc}, 32'd1);
    d0(0, 1, BS, 32'h0000_0023, 0);
    chk("byte_noexc", {31'b0, bus0.addr_exc}, 32'd0); chk("lb_23", bus0.rd, 32'h0000_007F);
    d0(0, 1, W,  32'h0000_0020, 0); chk("keep_20",  bus0.rd, 32'h7FFF_8001);
    d0(0, 1, W,  32'h0000_0FFC, 0); chk("keep_ffc", bus0.rd, 32'hA5A5_A5A5);
    d0(0, 1, W,  32'h0000_0000, 0); chk("keep_0",   bus0.rd, 32'h0);
    d0(0, 0, W,  32'h0000_0020, 0); chk("noread_rd", bus0.rd, 32'h0);

    // Same-cycle read/write on the combinational port sees old data
    d0(1, 1, W,  32'h0000_0020, 32'h0102_0304); chk("rw_old0", bus0.rd, 32'h7FFF_8001);
    d0(0, 1, W,  32'h0000_0020, 0); chk("rw_new0", bus0.rd, 32'h0102_0304);
    d0(0, 0, W,  0, 0);

    // Registered read port
    d1(1, 0, W, 32'h1000_0040, 32'h0000_0005);
    d1(1, 1, W, 32'h1000_0040, 32'hDEAD_BEEF); chk("r1_prev", bus1.rd, 32'h0);
    d1(0, 1, W, 32'h1000_0040, 0);             chk("r1_old",  bus1.rd, 32'h0000_0005);
    d1(0, 0, W, 32'h1000_0040, 0);             chk("r1_new",  bus1.rd, 32'hDEAD_BEEF);
    d1(0, 1, W, 32'h0FFF_FFFC, 0); chk("r1_exc_lo", {31'b0, bus1.addr_exc}, 32'd1);
    d1(0, 1, W, 32'h1000_0100, 0); chk("r1_exc_hi", {31'b0, bus1.addr_exc}, 32'd1);
    d1(0, 0, W, 32'h1000_0000, 0); chk("r1_exc_rd", bus1.rd, 32'h0);
    d1(1, 0, BU, 32'h1000_00FD, 32'h0000_0080);
    d1(0, 1, BS, 32'h1000_00FD, 0); chk("r1_inrange", {31'b0, bus1.addr_exc}, 32'd0);
    d1(0, 0, W, 32'h1000_0000, 0); chk("r1_lb", bus1.rd, 32'hFFFF_FF80);
    d1(0, 1, W, 32'h1000_0040, 0);
    d1(0, 1, W, 32'h1000_0040, 0); chk("r1_hold", bus1.rd, 32'hDEAD_BEEF);

    // Reset mid-run, then again mid-clear
    @(negedge clk); reset = 1'b0; #2;
    chk("rst2_rd1",   bus1.rd, 32'h0);
    chk("rst2_busy0", {31'b0, bus0.busy}, 32'd1);
    repeat (2) @(negedge clk);
    @(negedge clk); reset = 1'b1;
    busy_ok = 1'b1;
    for (int k = 0; k < 500; k++) begin
      d0(1, 0, W, 32'h0000_0030, 32'h1234_5678);
      if (!bus0.busy || bus0.addr_exc || bus1.rd !== 32'h0) busy_ok = 1'b0;
    end
    chk("clear_busy_window", {31'b0, busy_ok}, 32'd1);
    @(negedge clk); reset = 1'b0;
    d0(0, 0, W, 0, 0);
    repeat (3) @(negedge clk);
    release_and_count(c0, c1);
    chk("busy_cnt0_b", c0, 32'd1024);
    chk("busy_cnt1_b", c1, 32'd64);
    d0(0, 1, W, 32'h0000_0030, 0); chk("drop_busy_30", bus0.rd, 32'h0);
    d0(0, 1, W, 32'h0000_0020, 0); chk("reclr_20",     bus0.rd, 32'h0);
    d0(0, 1, W, 32'h0000_0FFC, 0); chk("reclr_ffc",    bus0.rd, 32'h0);
    d1(0, 1, W, 32'h1000_0040, 0);
    d1(0, 0, W, 32'h1000_0040, 0); chk("r1_reclr", bus1.rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
